// File: rtl/round_key_bank_if.sv
// Capture and read-port signal bundle between the key schedule, round datapath and the round-key bank.
interface round_key_bank_if #(
  parameter int unsigned KEY_W = 128
);
  logic             ks_valid;
  logic [3:0]       ks_round;
  logic [KEY_W-1:0] omega_key;
  logic             clear;
  logic             keys_ready;
  logic             rd_en;
  logic [3:0]       rd_round;
  logic             rd_dec;
  logic [KEY_W-1:0] rd_key;
  logic             rd_valid;
  logic             err;

  modport master (
    output ks_valid, ks_round, omega_key, clear, rd_en, rd_round, rd_dec,
    input  keys_ready, rd_key, rd_valid, err
  );

  modport slave (
    input  ks_valid, ks_round, omega_key, clear, rd_en, rd_round, rd_dec,
    output keys_ready, rd_key, rd_valid, err
  );
endinterface

// File: rtl/round_key_bank.sv
// Captures omega's extracted round keys into a ROUNDS+1 entry bank and serves them
// in encryption or reversed (decryption) order through a registered read port.
module round_key_bank #(
  parameter int unsigned ROUNDS    = 12,
  parameter int unsigned OMEGA_LAT = 1,
  parameter int unsigned KEY_W     = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  round_key_bank_if.slave  bus
);
  localparam int unsigned RW    = 4;
  localparam int unsigned NKEYS = ROUNDS + 1;

  logic [KEY_W-1:0] r_bank [NKEYS];
  logic [NKEYS-1:0] r_mask;
  logic             r_pv   [OMEGA_LAT];
  logic [RW-1:0]    r_pr   [OMEGA_LAT];
  logic             r_keys_ready;
  logic             r_rd_valid;
  logic [KEY_W-1:0] r_rd_key;
  logic             r_err;

  logic             w_wr_v;
  logic [RW-1:0]    w_wr_round;
  logic             w_wr_in_range;
  logic             w_wr_en;
  logic             w_wr_dup;
  logic             w_wr_bad;
  logic             w_rd_legal;
  logic             w_rd_illegal;
  logic [RW-1:0]    w_rd_addr;
  logic [NKEYS-1:0] w_mask_nxt;

  assign w_wr_v        = r_pv[OMEGA_LAT-1];
  assign w_wr_round    = r_pr[OMEGA_LAT-1];
  assign w_wr_in_range = (w_wr_round <= RW'(ROUNDS));
  assign w_wr_en       = w_wr_v && w_wr_in_range && !bus.clear;
  assign w_wr_dup      = w_wr_en && (w_wr_round != '0) && r_mask[w_wr_round];
  assign w_wr_bad      = w_wr_v && !w_wr_in_range;

  assign w_rd_legal    = bus.rd_en && r_keys_ready && (bus.rd_round <= RW'(ROUNDS));
  assign w_rd_illegal  = bus.rd_en && !w_rd_legal;
  assign w_rd_addr     = bus.rd_dec ? (RW'(ROUNDS) - bus.rd_round) : bus.rd_round;

  // A round-0 write restarts the schedule, so the mask collapses to just bit 0.
  always_comb begin
    w_mask_nxt = r_mask;
    if (bus.clear) begin
      w_mask_nxt = '0;
    end else if (w_wr_en) begin
      if (w_wr_round == '0) begin
        w_mask_nxt = NKEYS'(1);
      end else begin
        w_mask_nxt[w_wr_round] = 1'b1;
      end
    end
  end

  // Delay ks_valid/ks_round to line up with omega's extract_key latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OMEGA_LAT); i++) begin
        r_pv[i] <= 1'b0;
        r_pr[i] <= '0;
      end
    end else begin
      r_pv[0] <= bus.ks_valid && !bus.clear;
      r_pr[0] <= bus.ks_round;
      for (int i = 1; i < int'(OMEGA_LAT); i++) begin
        r_pv[i] <= r_pv[i-1] && !bus.clear;
        r_pr[i] <= r_pr[i-1];
      end
    end
  end

  // Key storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_bank[w_wr_round] <= bus.omega_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= '0;
      r_keys_ready <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_key     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      if (bus.clear) begin
        r_keys_ready <= 1'b0;
        r_rd_valid   <= 1'b0;
        r_err        <= 1'b0;
      end else begin
        r_keys_ready <= &r_mask;
        r_rd_valid   <= w_rd_legal;
        if (w_rd_legal) begin
          r_rd_key <= r_bank[w_rd_addr];
        end
        if (w_wr_dup || w_wr_bad || w_rd_illegal) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.keys_ready = r_keys_ready;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_key     = r_rd_key;
  assign bus.err        = r_err;
endmodule
